// File: rtl/gray_code_conv.sv
// rtl/gray_code_conv.sv - Gray/binary converter with valid/ready handshake and transfer counter
// Optional GRAY_CODE_CONV_PIPE_EN adds a second output register stage (latency 2).
module gray_code_conv #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_mode,
  output logic [CNT_W-1:0] xfer_cnt
);

  function automatic logic [WIDTH-1:0] convert(input logic [WIDTH-1:0] d, input logic mode);
    logic [WIDTH-1:0] r;
    r = '0;
    r[WIDTH-1] = d[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      r[i] = mode ? (d[i+1] ^ d[i]) : (r[i+1] ^ d[i]);
    end
    return r;
  endfunction

  logic             rdy_q;
  logic             in_xfer;
  logic             out_xfer;
  logic [WIDTH-1:0] conv_data;
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_data_q, s1_data_d;
  logic             s1_mode_q, s1_mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;
  assign conv_data = convert(in_data, in_mode);

  // Holds in_ready low until the first clock edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdy_q <= 1'b0;
    else     rdy_q <= 1'b1;
  end

`ifdef GRAY_CODE_CONV_PIPE_EN
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_data_q, s2_data_d;
  logic             s2_mode_q, s2_mode_d;
  logic             s1_adv;

  assign s1_adv    = s1_valid_q & (~s2_valid_q | out_ready);
  assign in_ready  = rdy_q & (~s1_valid_q | s1_adv);
  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_mode  = s2_mode_q;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_mode_d  = s1_mode_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_mode_d  = s2_mode_q;
    if (in_xfer) begin
      s1_valid_d = 1'b1;
      s1_data_d  = conv_data;
      s1_mode_d  = in_mode;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
    if (s1_adv) begin
      s2_valid_d = 1'b1;
      s2_data_d  = s1_data_q;
      s2_mode_d  = s1_mode_q;
    end else if (out_xfer) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_mode_q  <= 1'b0;
    end else begin
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_mode_q  <= s2_mode_d;
    end
  end
`else
  assign in_ready  = rdy_q & (~s1_valid_q | out_ready);
  assign out_valid = s1_valid_q;
  assign out_data  = s1_data_q;
  assign out_mode  = s1_mode_q;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_mode_d  = s1_mode_q;
    if (in_xfer) begin
      s1_valid_d = 1'b1;
      s1_data_d  = conv_data;
      s1_mode_d  = in_mode;
    end else if (out_xfer) begin
      s1_valid_d = 1'b0;
    end
  end
`endif

  always_comb begin
    cnt_d = cnt_q;
    if (out_xfer) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_mode_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_mode_q  <= s1_mode_d;
      cnt_q      <= cnt_d;
    end
  end

  assign xfer_cnt = cnt_q;

endmodule

// File: doc/gray_code_conv.md
GRAY_CODE_CONV -- requirements
Module: gray_code_conv

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the code word width in bits; legal range is 2 to 32.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of the transfer counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  upstream presents a word.
REQ-006 in_ready  output  1  block can accept a word this cycle.
REQ-007 in_data  input  WIDTH  code word to convert.
REQ-008 in_mode  input  1  conversion mode: 0 = Gray to binary, 1 = binary to Gray; sampled with in_data.
REQ-009 out_valid  output  1  converted word is available.
REQ-010 out_ready  input  1  downstream accepts the word.
REQ-011 out_data  output  WIDTH  converted word.
REQ-012 out_mode  output  1  mode used to produce out_data.
REQ-013 xfer_cnt  output  CNT_W  count of output transfers completed since reset.

Function
REQ-014 An input transfer SHALL occur on a rising edge where in_valid and in_ready are both 1; an output transfer SHALL occur where out_valid and out_ready are both 1.
REQ-015 In Gray to binary mode: out[WIDTH-1] SHALL equal in[WIDTH-1], and out[i] SHALL equal out[i+1] XOR in[i] for i from WIDTH-2 down to 0.
REQ-016 In binary to Gray mode: out[WIDTH-1] SHALL equal in[WIDTH-1], and out[i] SHALL equal in[i+1] XOR in[i].
REQ-017 Each pipeline stage SHALL hold one word plus a valid flag; the stage SHALL load when it is empty or when its contents transfer to the next stage in the same cycle.
REQ-018 in_ready SHALL equal NOT out_valid OR out_ready in single-stage builds; in_ready SHALL be combinational from out_ready, with no other combinational path from input to output.
REQ-019 When out_valid is 1 and out_ready is 0, out_data, out_mode and out_valid SHALL hold stable until the output transfer occurs.
REQ-020 A simultaneous input and output transfer on the same edge SHALL load the new word, and out_valid SHALL remain 1 with no bubble.
REQ-021 Throughput SHALL be one word per cycle whenever out_ready is held at 1.
REQ-022 Latency SHALL be 1 cycle from an input transfer to out_valid in the base build.
REQ-023 xfer_cnt SHALL increment by 1 on every output transfer and SHALL wrap from 2^CNT_W-1 to 0.
REQ-024 Words SHALL leave the block in acceptance order, and none SHALL be dropped or duplicated.

Reset
REQ-025 While rst is 1, out_valid, out_data, out_mode and xfer_cnt SHALL be 0.
REQ-026 While rst is 1, every internal valid flag SHALL be 0, and in_ready SHALL be 0.
REQ-027 A word in flight SHALL be discarded when rst asserts mid-operation, with no partial output.
REQ-028 in_ready SHALL reach 1 on the first rising edge after rst deasserts.

Configuration
REQ-029 The macro GRAY_CODE_CONV_PIPE_EN SHALL add a second register stage after the XOR network, making latency 2 cycles.
REQ-030 With GRAY_CODE_CONV_PIPE_EN, each stage SHALL follow REQ-017, and in_ready SHALL be 1 whenever stage 1 is empty or stage 1 can advance.
REQ-031 With GRAY_CODE_CONV_PIPE_EN, throughput SHALL remain one word per cycle and two words SHALL be buffered under backpressure.
REQ-032 Without GRAY_CODE_CONV_PIPE_EN, the block SHALL have exactly one register stage and latency 1, and all other behaviour SHALL be identical.

Verification
REQ-033 WIDTH=4, mode 0, in_data 4'b1011, out_ready=1 -> out_data 4'b1101, out_mode 0, after 1 cycle (2 with the pipe macro).
REQ-034 WIDTH=4, mode 1, in_data 4'b1101 -> out_data 4'b1011; WIDTH=8, mode 0, in_data 8'hFF -> out_data 8'hAA.
REQ-035 Stream 16 words with out_ready=1 -> 16 consecutive out_valid cycles, order preserved, xfer_cnt=16.
REQ-036 Hold out_ready=0 for 5 cycles with a word pending -> out_data stable, in_ready 0 once full; release out_ready -> no loss or duplication.
REQ-037 Preload xfer_cnt to 2^CNT_W-1 by streaming transfers, then do one more transfer -> xfer_cnt wraps to 0.
REQ-038 Assert rst while a word is pending with out_ready=0 -> out_valid, out_data and xfer_cnt read 0 immediately; in_ready reaches 1 one edge after rst deasserts.
